// File: rtl/harmonic_mixer_pkg.sv
// Shared definitions for the harmonic mixer: datapath widths, table geometry,
// sequencing constants and the controller state encoding.
// No ports; imported by sine_rom and harmonic_mixer.
package harmonic_defs;

    localparam int PHASE_W       = 22;
    localparam int SAMPLE_W      = 16;
    localparam int AMP_W         = 6;
    localparam int ACC_W         = SAMPLE_W + AMP_W + 3;
    localparam int ROM_AW        = 10;
    localparam int NUM_HARMONICS = 5;

    // Sum of five 6-bit weights needs 9 bits
    localparam int SUM_W = AMP_W + 3;

    // Shared sequencing counter, wide enough to count the divide iterations
    localparam int CNT_W = 5;
    localparam int IDX_W = 3;

    // Last counter value in LOOKUP (one slot per harmonic) and in DIVIDE
    // (one setup slot followed by ACC_W restoring iterations)
    localparam logic [CNT_W-1:0] LOOKUP_LAST = CNT_W'(NUM_HARMONICS - 1);
    localparam logic [CNT_W-1:0] DIVIDE_LAST = CNT_W'(ACC_W);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_DONE   = 2'd3
    } mixer_state_t;

endpackage

// File: rtl/harmonic_mixer_sine.sv
// Full-cycle sine table, 1024 x SAMPLE_W signed, with a one-cycle registered read.
// Entry i = round(32767 * sin(2*pi*i/1024)); contents are fixed at elaboration.
// Ports:
//   clk   - rising-edge clock for the read register
//   addr  - table index (top ROM_AW bits of a phase accumulator)
//   data  - registered signed table value, valid the cycle after addr
module sine_rom
    import harmonic_defs::*;
(
    input  logic                       clk,
    input  logic [ROM_AW-1:0]          addr,
    output logic signed [SAMPLE_W-1:0] data
);

    logic signed [SAMPLE_W-1:0] sine_table [2**ROM_AW];

    // Round half away from zero so the table stays odd-symmetric
    for (genvar i = 0; i < 2**ROM_AW; i++) begin : g_entry
        localparam real ANGLE  = 6.283185307179586 * i / 1024.0;
        localparam real SCALED = 32767.0 * $sin(ANGLE);
        localparam int  VALUE  = (SCALED >= 0.0) ? $rtoi(SCALED + 0.5)
                                                 : $rtoi(SCALED - 0.5);
        assign sine_table[i] = SAMPLE_W'(VALUE);
    end

    always_ff @(posedge clk) begin
        data <= sine_table[addr];
    end

endmodule

// File: rtl/harmonic_mixer.sv
// Harmonic mixer: per requested sample, looks up harmonics 1..5 of the current
// note from a shared sine table, accumulates amplitude-weighted values, then
// divides by the sum of weights with a sequential restoring divider.
// Ports:
//   clk, reset_n          - clock and asynchronous active-low reset
//   step_size             - fundamental phase increment per sample
//   load_new_note         - pulse: clear all phase accumulators
//   generate_next         - pulse: start computing the next sample (ignored when busy)
//   amplitude_1..5        - unsigned harmonic weights
//   sample_out            - signed normalized sample, held between results
//   sample_ready          - one-cycle pulse when sample_out updates
//   busy                  - high from the cycle after accept through the ready cycle
module harmonic_mixer
    import harmonic_defs::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [PHASE_W-1:0]         step_size,
    input  logic                       load_new_note,
    input  logic                       generate_next,
    input  logic [AMP_W-1:0]           amplitude_1,
    input  logic [AMP_W-1:0]           amplitude_2,
    input  logic [AMP_W-1:0]           amplitude_3,
    input  logic [AMP_W-1:0]           amplitude_4,
    input  logic [AMP_W-1:0]           amplitude_5,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_ready,
    output logic                       busy
);

    localparam int PROD_W = AMP_W + SAMPLE_W + 1;

    mixer_state_t state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   lookup_idx;
    logic               accept;
    logic               clear_phases;
    logic               pending_clear;

    logic [AMP_W-1:0]   amp   [NUM_HARMONICS];
    logic [PHASE_W-1:0] phase [NUM_HARMONICS];
    logic [PHASE_W-1:0] step;
    logic [PHASE_W-1:0] harmonic_step;
    logic [SUM_W-1:0]   sum_amp;

    logic [ROM_AW-1:0]          rom_addr;
    logic signed [SAMPLE_W-1:0] rom_data;

    logic                     mac_en;
    logic [IDX_W-1:0]         mac_idx;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]         acc_mag;

    logic [ACC_W-1:0]    quot;
    logic [ACC_W-1:0]    quot_next;
    logic [SUM_W-1:0]    rem;
    logic [SUM_W-1:0]    rem_next;
    logic [SUM_W:0]      rem_shift;
    logic                fits;
    logic                result_neg;
    logic [SAMPLE_W-1:0] result;

    assign accept     = (state == ST_IDLE) && generate_next;
    assign busy       = (state != ST_IDLE);
    assign lookup_idx = cnt[IDX_W-1:0];

    // Clears requested while busy are parked and applied on the way back to IDLE
    assign clear_phases = load_new_note && (state == ST_IDLE) ||
                          (state == ST_DONE) && (pending_clear || load_new_note);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (generate_next)        next_state = ST_LOOKUP;
            ST_LOOKUP: if (cnt == LOOKUP_LAST)   next_state = ST_DIVIDE;
            ST_DIVIDE: if (cnt == DIVIDE_LAST)   next_state = ST_DONE;
            ST_DONE:                             next_state = ST_IDLE;
            default:                             next_state = ST_IDLE;
        endcase
    end

    // Per-state counter, restarting at zero on every state change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (next_state != state) begin
            cnt <= '0;
        end else if (state != ST_IDLE) begin
            cnt <= cnt + 1'b1;
        end
    end

    // k * step built from shifts and adds, k = lookup_idx + 1
    always_comb begin
        harmonic_step = step;
        case (lookup_idx)
            3'd0:    harmonic_step = step;
            3'd1:    harmonic_step = step << 1;
            3'd2:    harmonic_step = (step << 1) + step;
            3'd3:    harmonic_step = step << 2;
            3'd4:    harmonic_step = (step << 2) + step;
            default: harmonic_step = step;
        endcase
    end

    // Latch weights and step on accept so later input changes cannot disturb the sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_HARMONICS; i++) amp[i] <= '0;
            step    <= '0;
            sum_amp <= '0;
        end else if (accept) begin
            amp[0]  <= amplitude_1;
            amp[1]  <= amplitude_2;
            amp[2]  <= amplitude_3;
            amp[3]  <= amplitude_4;
            amp[4]  <= amplitude_5;
            step    <= step_size;
            sum_amp <= SUM_W'(amplitude_1) + SUM_W'(amplitude_2) + SUM_W'(amplitude_3)
                     + SUM_W'(amplitude_4) + SUM_W'(amplitude_5);
        end
    end

    // Phase accumulators; each advances once per sample, in its own lookup slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_HARMONICS; i++) phase[i] <= '0;
        end else if (clear_phases) begin
            for (int i = 0; i < NUM_HARMONICS; i++) phase[i] <= '0;
        end else if (state == ST_LOOKUP) begin
            phase[lookup_idx] <= phase[lookup_idx] + harmonic_step;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_clear <= 1'b0;
        end else if (state == ST_DONE) begin
            pending_clear <= 1'b0;
        end else if (load_new_note && state != ST_IDLE) begin
            pending_clear <= 1'b1;
        end
    end

    assign rom_addr = phase[lookup_idx][PHASE_W-1 -: ROM_AW];

    sine_rom u_sine_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    // The MAC trails the lookup by one cycle, so the last product lands in the
    // first DIVIDE cycle; acc_next is used there to seed the divider.
    assign product  = $signed({1'b0, amp[mac_idx]}) * rom_data;
    assign acc_next = mac_en ? acc + ACC_W'(product) : acc;
    assign acc_mag  = acc_next[ACC_W-1] ? ACC_W'(-acc_next) : ACC_W'(acc_next);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mac_en  <= 1'b0;
            mac_idx <= '0;
            acc     <= '0;
        end else begin
            mac_en  <= (state == ST_LOOKUP);
            mac_idx <= lookup_idx;
            if (accept) begin
                acc <= '0;
            end else if (mac_en) begin
                acc <= acc_next;
            end
        end
    end

    // Restoring division step: the dividend shifts out of quot as quotient bits shift in.
    // A zero divisor makes every step "fit"; that case is forced to zero at the output.
    assign rem_shift = {rem, quot[ACC_W-1]};
    assign fits      = rem_shift >= {1'b0, sum_amp};
    assign rem_next  = fits ? SUM_W'(rem_shift - {1'b0, sum_amp}) : SUM_W'(rem_shift);
    assign quot_next = {quot[ACC_W-2:0], fits};
    assign result    = result_neg ? SAMPLE_W'(-quot_next) : SAMPLE_W'(quot_next);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quot       <= '0;
            rem        <= '0;
            result_neg <= 1'b0;
        end else if (state == ST_DIVIDE) begin
            if (cnt == '0) begin
                quot       <= acc_mag;
                rem        <= '0;
                result_neg <= acc_next[ACC_W-1];
            end else begin
                quot <= quot_next;
                rem  <= rem_next;
            end
        end
    end

    // Result and ready pulse are registered together on the final divide step
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_out   <= '0;
            sample_ready <= 1'b0;
        end else if (state == ST_DIVIDE && cnt == DIVIDE_LAST) begin
            sample_out   <= (sum_amp == '0) ? '0 : $signed(result);
            sample_ready <= 1'b1;
        end else begin
            sample_ready <= 1'b0;
        end
    end

endmodule

// File: tb/tb_harmonic_mixer.sv
// Directed testbench for harmonic_mixer. Drives whole-sample transactions with
// hand-computed expected outputs and checks latency, busy and sample_ready.
module tb_harmonic_mixer;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [21:0]        step_size;
    logic               load_new_note;
    logic               generate_next;
    logic [5:0]         amplitude_1, amplitude_2, amplitude_3, amplitude_4, amplitude_5;
    logic signed [15:0] sample_out;
    logic               sample_ready;
    logic               busy;

    int vectorCount = 0;
    int missCount   = 0;

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    harmonic_mixer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .step_size     (step_size),
        .load_new_note (load_new_note),
        .generate_next (generate_next),
        .amplitude_1   (amplitude_1),
        .amplitude_2   (amplitude_2),
        .amplitude_3   (amplitude_3),
        .amplitude_4   (amplitude_4),
        .amplitude_5   (amplitude_5),
        .sample_out    (sample_out),
        .sample_ready  (sample_ready),
        .busy          (busy)
    );

    // Counts one comparison and reports it when it misses
    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic setInputs(input logic [5:0] a1, a2, a3, a4, a5, input logic [21:0] step);
        amplitude_1 = a1;
        amplitude_2 = a2;
        amplitude_3 = a3;
        amplitude_4 = a4;
        amplitude_5 = a5;
        step_size   = step;
    endtask

    // Garbage on the inputs after accept; the DUT must have latched its copies
    task automatic scrambleInputs();
        setInputs(6'h3F, 6'h2A, 6'h15, 6'h3F, 6'h3F, 22'h2AAAAA);
    endtask

    // One full sample: accept, bounded wait for ready, check value, latency, busy
    task automatic applyStimulus(input string tag, input logic [5:0] a1, a2, a3, a4, a5,
                                 input logic [21:0] step, input bit doLoad,
                                 input int expSample);
        int  latency;
        bit  found;
        setInputs(a1, a2, a3, a4, a5, step);
        load_new_note = doLoad;
        generate_next = 1'b1;
        @(posedge clk); #1;
        generate_next = 1'b0;
        load_new_note = 1'b0;
        scrambleInputs();
        checkOutput({tag, " busy after accept"}, int'(busy), 1);
        latency = 0;
        found   = 1'b0;
        // After edge accept+cyc the bench is inside cycle accept+cyc+1
        for (int cyc = 1; cyc <= 60 && !found; cyc++) begin
            @(posedge clk); #1;
            if (sample_ready) begin
                found   = 1'b1;
                latency = cyc + 1;
            end
        end
        if (!found) begin
            checkOutput({tag, " ready timeout"}, 0, 1);
        end else begin
            checkOutput({tag, " latency"}, latency, 32);
            checkOutput({tag, " sample"}, int'(sample_out), expSample);
            checkOutput({tag, " busy at ready"}, int'(busy), 1);
            @(posedge clk); #1;
            checkOutput({tag, " ready pulse width"}, int'(sample_ready), 0);
            checkOutput({tag, " busy after ready"}, int'(busy), 0);
            checkOutput({tag, " sample held"}, int'(sample_out), expSample);
        end
    endtask

    initial begin
        int  readyCount;
        int  readyAt;
        int  sampleAtReady;

        reset_n       = 1'b0;
        load_new_note = 1'b0;
        generate_next = 1'b0;
        setInputs('0, '0, '0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset sample_out", int'(sample_out), 0);
        checkOutput("reset sample_ready", int'(sample_ready), 0);
        checkOutput("reset busy", int'(busy), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single fundamental, quarter-cycle step: index 0 then 256
        applyStimulus("fund s1", 6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 22'h100000, 1'b1, 0);
        applyStimulus("fund s2", 6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 22'h100000, 1'b0, 32767);

        // Mixed weights; second sample hits indices 256,512,768,0,256:
        // acc = 2*32767 - 10*32767 = -262136, /21 -> -12482 (toward zero)
        applyStimulus("mix s1", 6'd2, 6'd4, 6'd10, 6'd5, 6'd0, 22'h100000, 1'b1, 0);
        applyStimulus("mix s2", 6'd2, 6'd4, 6'd10, 6'd5, 6'd0, 22'h100000, 1'b0, -12482);

        // All weights zero: result zero, latency unchanged
        applyStimulus("zero amps", 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 22'h123456, 1'b0, 0);

        // Index step 768 wraps: 0,768,512,256,0
        applyStimulus("wrap s1", 6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 22'h300000, 1'b1, 0);
        applyStimulus("wrap s2", 6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 22'h300000, 1'b0, -32767);
        applyStimulus("wrap s3", 6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 22'h300000, 1'b0, 0);
        applyStimulus("wrap s4", 6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 22'h300000, 1'b0, 32767);
        applyStimulus("wrap s5", 6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 22'h300000, 1'b0, 0);

        // Fundamental phase now 0x300000 (index 768). Extra generate pulses while
        // busy are dropped; a clear requested mid-sample waits for the sample to finish.
        setInputs(6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 22'h080000);
        generate_next = 1'b1;
        @(posedge clk); #1;
        generate_next = 1'b0;
        readyCount    = 0;
        readyAt       = 0;
        sampleAtReady = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            generate_next = (cyc == 3) || (cyc == 20);
            load_new_note = (cyc == 10);
            @(posedge clk); #1;
            if (sample_ready) begin
                readyCount++;
                if (readyAt == 0) begin
                    readyAt       = cyc + 1;
                    sampleAtReady = int'(sample_out);
                end
            end
        end
        generate_next = 1'b0;
        load_new_note = 1'b0;
        checkOutput("drop ready count", readyCount, 1);
        checkOutput("drop latency", readyAt, 32);
        checkOutput("drop old phase sample", sampleAtReady, -32767);
        checkOutput("drop idle busy", int'(busy), 0);
        // Without the deferred clear this would read index 896 (nonzero)
        applyStimulus("deferred clear", 6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 22'h080000, 1'b0, 0);

        // Put a nonzero value on sample_out, then reset in the middle of a divide
        applyStimulus("pre-reset s1", 6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 22'h100000, 1'b1, 0);
        applyStimulus("pre-reset s2", 6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 22'h100000, 1'b0, 32767);
        generate_next = 1'b1;
        @(posedge clk); #1;
        generate_next = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("mid-divide busy", int'(busy), 1);
        reset_n = 1'b0;
        #2;
        checkOutput("async reset sample_out", int'(sample_out), 0);
        checkOutput("async reset sample_ready", int'(sample_ready), 0);
        checkOutput("async reset busy", int'(busy), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus("post-reset s1", 6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 22'h100000, 1'b1, 0);
        applyStimulus("post-reset s2", 6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 22'h100000, 1'b0, 32767);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/harmonic_mixer.md
Name: harmonic_mixer

Overview:
Consumes the five per-voicing harmonic weights (amplitude_1..5, 6-bit unsigned) and the current note's phase step. For each requested audio sample it produces one signed sample: the weighted sum of harmonics 1..5 of a sine, normalized by the sum of weights. It sits between the note player/voicing selector and the codec output path, and runs a time-multiplexed sine lookup followed by a sequential divider.

Parameters:
PHASE_W, 22, phase accumulator width; the top 10 bits index the sine table
SAMPLE_W, 16, signed sample width (sine table and output)
AMP_W, 6, harmonic weight width
ACC_W, 25, accumulator width (SAMPLE_W+AMP_W+3); also the divider iteration count

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
step_size  in  PHASE_W  fundamental phase increment per sample
load_new_note  in  1  one-cycle pulse: clear all phase accumulators
generate_next  in  1  one-cycle pulse: compute the next sample
amplitude_1..amplitude_5  in  AMP_W each  harmonic weights, unsigned
sample_out  out  SAMPLE_W  signed normalized sample, held until next result
sample_ready  out  1  one-cycle pulse when sample_out updates
busy  out  1  high from the cycle after accept until the sample_ready cycle, inclusive

Behaviour:
- Reset (asynchronous, any state): sample_out=0, sample_ready=0, busy=0, all five phases=0, pending-clear=0, FSM=IDLE.
- FSM states: IDLE -> LOOKUP -> DIVIDE -> DONE -> IDLE.
- IDLE: when generate_next=1, accept. Latch amplitude_1..5 and step_size, set sum_amp = sum of weights (9-bit), clear acc, go to LOOKUP. Inputs changing after accept are ignored.
- LOOKUP, 5 cycles, k=1..5: issue sine address phase_k[PHASE_W-1 -: 10], then phase_k <= phase_k + k*step (mod 2^PHASE_W, wraps silently; k*step built from shift/add). ROM data returns one cycle later. acc += amplitude_k * sine (signed), so the last MAC lands in the first DIVIDE cycle.
- DIVIDE: restoring divide of |acc| by sum_amp, ACC_W iterations, one bit per cycle. Quotient truncates toward zero, and the sign of acc is reapplied. No saturation is needed: |quotient| is at most 32767, and -32768 is reachable only from a table value of -32768.
- sum_amp=0: the divide is skipped in effect. The result is 0, but the fixed latency is kept.
- DONE: sample_out <= result, sample_ready=1 for one cycle, then return to IDLE.
- Latency: sample_ready is asserted exactly 7+ACC_W = 32 cycles after the generate_next accept cycle. The next accept is possible in the cycle after sample_ready.
- generate_next while busy or in DONE: dropped, no queueing.
- load_new_note in IDLE: phases clear at that edge. If it coincides with generate_next, the clear applies first, so the lookups use phase 0.
- load_new_note while busy: sets pending-clear. The clear is applied on the DONE->IDLE edge. The in-flight sample completes with the old phases.

Decomposition:
- Shared package (harmonic_defs): PHASE_W, SAMPLE_W, AMP_W, ACC_W, ROM address width (10), NUM_HARMONICS=5, FSM state encodings.
- Sub-module sine_rom: 1024 x SAMPLE_W full-cycle table, entry i = round(32767*sin(2*pi*i/1024)), 1-cycle registered read. Entries 0 and 512 are 0, entry 256 is 32767, entry 768 is -32767.

Test Plan:
1. Assert reset_n=0 mid-DIVIDE, then release -> sample_out=0, sample_ready=0, busy=0. The next generate_next after load_new_note starts from phase 0 (result 0 with step 0x100000).
2. Amps (1,0,0,0,0), step_size=0x100000, then load_new_note and generate_next twice, 32+ cycles apart -> first sample 0, second sample 32767. Each sample_ready is exactly 32 cycles after its accept.
3. Amps (2,4,10,5,0), step 0x100000, second sample (addresses 256,512,768,0,256) -> acc = -262136, sum=21, sample_out = -12482.
4. Amps all 0, any step -> sample_out=0, sample_ready still pulses at cycle 32, busy drops.
5. generate_next pulses at accept+3 and accept+20 -> exactly one sample_ready. load_new_note at accept+10 -> the current sample uses the old phase, the next sample uses phase 0.
6. Amps (1,0,0,0,0), step 0x300000, 5 consecutive samples -> index sequence 0,768,512,256,0 (wrap), outputs 0, -32767, 0, 32767, 0.
